edge_detect_filt: RTL
=====================

# edge_detect_filt

Multi-channel, parametrised edge detector for asynchronous inputs such as buttons, external triggers and sync strobes in the waveform-generator control path. Each channel synchronises its input and debounces it with a programmable stability count. It then emits a one-cycle pulse on rising, falling or both edges. A sticky per-channel event flag and an aggregate interrupt output let the CSR logic poll or clear the channels.

## Interface
- WIDTH, 4: number of independent channels, ≥1.
- SYNC_STAGES, 2: synchroniser flops per channel, ≥2.
- DEB_W, 8: width of the debounce length and of each per-channel counter.

- i_clk  in  1  clock.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_detect_in  in  WIDTH  raw asynchronous inputs.
- i_mode  in  2  global edge select: 00 off, 01 rise, 10 fall, 11 both.
- i_deb_len  in  DEB_W  debounce length N; 0 = no filtering.
- i_event_clr  in  WIDTH  write-1-to-clear for o_event and o_ovf.
- o_level  out  WIDTH  filtered level.
- o_pulse  out  WIDTH  one-cycle pulse on each qualified edge.
- o_event  out  WIDTH  sticky qualified-edge flag.
- o_ovf  out  WIDTH  sticky overflow flag (see Configuration).
- o_irq  out  1  combinational OR-reduction of o_event.

## Operation
Each channel runs independently, in this order:
- **Synchroniser:** a SYNC_STAGES-deep flop chain. s is the last stage.
- **Debounce:** the counter cnt tracks how long s has disagreed with o_level.
  - s == o_level: cnt <= 0.
  - s != o_level and cnt >= i_deb_len: o_level <= s, cnt <= 0. This is the toggle.
  - s != o_level and cnt < i_deb_len: cnt <= cnt+1.
  - Net effect: s must disagree with o_level for N+1 consecutive cycles before o_level toggles.
  - Any agreeing cycle restarts the count.
  - The >= compare keeps the counter correct if i_deb_len is lowered mid-count.
  - cnt never exceeds max(i_deb_len, previous value) and never wraps.
- **Qualification:** a toggle is qualified when:
  - 0→1 with i_mode[0]=1, or
  - 1→0 with i_mode[1]=1.
  - i_mode=00 suppresses pulses and events; filtering continues.
- **o_pulse:** registered. Asserted for exactly one cycle, coincident with the o_level update on a qualified toggle.
- **o_event:**
  - Set on a qualified toggle.
  - Cleared at the next edge when i_event_clr bit = 1.
  - Simultaneous set and clear: set wins.
- **o_irq:** = |o_event. No extra latency.
- **i_mode and i_deb_len:** sampled every cycle. A change affects the next evaluation only and never produces a spurious pulse.

## Timing
- **Reset values:**
  - All synchroniser flops, cnt, o_level, o_pulse, o_event and o_ovf are 0.
  - o_irq = 0.
- **Reset mid-operation:** clears everything immediately (asynchronous) and drops any pulse in progress.
- **Input held high across reset release:** produces a normal qualified rising edge after full latency. This is intended, because the reset level is 0.
- **Latency:** an input change captured at edge k updates o_level and o_pulse at edge k + SYNC_STAGES + N. With defaults and N=0, o_level and o_pulse update at edge k+2.
- **Event and pulse timing:** o_event rises in the same cycle as o_pulse. o_irq follows combinationally.
- **Back-to-back toggles:** these are possible only with N=0. Pulses may then occur on consecutive cycles, one per toggle.
- **Clear timing:** i_event_clr takes effect at the next rising edge. A clear asserted for multiple cycles holds the flags low, except in a cycle where a new qualified edge sets o_event.

## Configuration
- **EDGE_DET_OVF_EN defined:** o_ovf[i] sets when a qualified toggle occurs while o_event[i] = 1 and i_event_clr[i] = 0 in that cycle.
  - It clears with i_event_clr[i]. Set wins, as for o_event.
  - It does not affect o_irq.
- **EDGE_DET_OVF_EN undefined:** o_ovf is tied to 0 and no overflow logic is synthesised.

## Test plan
- **Reset state:** WIDTH=4, defaults. Assert i_rst_n=0 mid-stream with o_event=4'b1010 → all outputs 0 immediately. After release, no pulse while inputs stay 0.
- **Rising edge, no filter:** i_mode=01, N=0. Ch0 rises, sampled at edge k → o_level[0]=1 and o_pulse[0]=1 at edge k+2 for one cycle. o_event[0]=1, o_irq=1. Ch0 falls → no pulse.
- **Debounce:** i_mode=11, N=3.
  - Ch1 glitches high for 3 cycles → no change on o_level, o_pulse or o_event.
  - Ch1 holds high for 4 cycles → o_level[1] rises 5 cycles after capture, with one pulse.
- **Both-edges mode:** i_mode=11, N=0. Ch2 pulses high for 1 cycle → two o_pulse[2] pulses on consecutive cycles.
- **Clear versus set:** i_event_clr[3]=1 in the same cycle as a qualified edge on ch3 → o_event[3] stays 1. i_event_clr[3]=1 alone on the next cycle → 0.
- **Overflow (EDGE_DET_OVF_EN):** two qualified edges on ch0 without a clear → o_ovf[0]=1. i_event_clr[0]=1 → o_event[0]=0 and o_ovf[0]=0. Without the macro, o_ovf stays 0 throughout.

Source files
------------

// File: rtl/edge_detect_filt.sv
// edge_detect_filt: multi-channel synchronise / debounce / edge-detect block.
//
// Each of the WIDTH channels owns a SYNC_STAGES-deep synchroniser, a DEB_W-bit
// debounce counter and a filtered level. A filtered toggle produces a one-cycle
// o_pulse and sets a sticky o_event flag when i_mode selects that direction.
// o_irq is the OR of all event flags.
//
// Optional feature macro: EDGE_DET_OVF_EN
//   defined   -> o_ovf[i] records a qualified toggle that arrived while
//                o_event[i] was still set and not being cleared.
//   undefined -> o_ovf is tied to zero and no overflow flops exist.
//
// Handshake note: there is no valid/ready flow here. Inputs are sampled every
// cycle; i_event_clr is a write-1-to-clear strobe that acts at the next edge,
// and a qualified toggle in the same cycle takes priority over the clear.

module edge_detect_filt #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_W       = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_detect_in,
    input  logic [1:0]       i_mode,
    input  logic [DEB_W-1:0] i_deb_len,
    input  logic [WIDTH-1:0] i_event_clr,
    output logic [WIDTH-1:0] o_level,
    output logic [WIDTH-1:0] o_pulse,
    output logic [WIDTH-1:0] o_event,
    output logic [WIDTH-1:0] o_ovf,
    output logic             o_irq
);

    // Edge-select decode, shared by all channels.
    logic rise_en;
    logic fall_en;

    assign rise_en = i_mode[0];
    assign fall_en = i_mode[1];

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch

        // Synchroniser chain; sync_q[SYNC_STAGES-1] is the last stage.
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s;

        // Debounce state.
        logic [DEB_W-1:0] cnt_q;
        logic [DEB_W-1:0] cnt_d;
        logic             level_q;
        logic             level_d;

        // Toggle qualification and sticky flags.
        logic disagree;
        logic toggle;
        logic qual;
        logic pulse_q;
        logic event_q;
        logic event_d;

        // Shift the raw input through the synchroniser flops.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], i_detect_in[gi]};
            end
        end

        assign s = sync_q[SYNC_STAGES-1];

        // Debounce: count disagreeing cycles, toggle once the count reaches
        // the programmed length. The >= compare lets a mid-count reduction of
        // i_deb_len toggle immediately instead of running the counter past it,
        // so the counter can never wrap.
        always_comb begin
            cnt_d    = cnt_q;
            level_d  = level_q;
            disagree = (s != level_q);
            toggle   = 1'b0;
            if (!disagree) begin
                cnt_d = '0;
            end else if (cnt_q >= i_deb_len) begin
                toggle  = 1'b1;
                level_d = s;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + DEB_W'(1);
            end
        end

        // Qualify the toggle against the edge-select mode using the level
        // before the update (0 -> 1 is a rise, 1 -> 0 is a fall).
        always_comb begin
            qual = 1'b0;
            if (toggle) begin
                qual = level_q ? fall_en : rise_en;
            end
        end

        // Sticky event: a qualified toggle beats a simultaneous clear.
        always_comb begin
            event_d = event_q;
            if (qual) begin
                event_d = 1'b1;
            end else if (i_event_clr[gi]) begin
                event_d = 1'b0;
            end
        end

        // Register debounce state, filtered level, pulse and event.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                cnt_q   <= '0;
                level_q <= 1'b0;
                pulse_q <= 1'b0;
                event_q <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                level_q <= level_d;
                pulse_q <= qual;
                event_q <= event_d;
            end
        end

        assign o_level[gi] = level_q;
        assign o_pulse[gi] = pulse_q;
        assign o_event[gi] = event_q;

`ifdef EDGE_DET_OVF_EN
        logic ovf_q;
        logic ovf_d;

        // Overflow: a second qualified toggle while the event is still
        // pending and not being cleared this cycle. Clear otherwise wins.
        always_comb begin
            ovf_d = ovf_q;
            if (qual && event_q && !i_event_clr[gi]) begin
                ovf_d = 1'b1;
            end else if (i_event_clr[gi]) begin
                ovf_d = 1'b0;
            end
        end

        // Register the overflow flag.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                ovf_q <= 1'b0;
            end else begin
                ovf_q <= ovf_d;
            end
        end

        assign o_ovf[gi] = ovf_q;
`else
        assign o_ovf[gi] = 1'b0;
`endif

    end : g_ch

    // Interrupt is the plain OR of the event flags, no extra register.
    assign o_irq = |o_event;

endmodule : edge_detect_filt
